// File: rtl/clint_split_pkg.sv
// Shared types for the CLINT burst-to-single-beat splitter: FSM states,
// AXI burst/response encodings and the write-response merge rule.
package clint_split_pkg;

  typedef enum logic [2:0] {
    W_IDLE,
    W_ADDR,
    W_DATA,
    W_RESP,
    W_BRESP
  } wrState_e;

  typedef enum logic [1:0] {
    R_IDLE,
    R_ADDR,
    R_DATA
  } rdState_e;

  localparam logic [1:0] BURST_FIXED = 2'b00;
  localparam logic [1:0] BURST_INCR  = 2'b01;
  localparam logic [1:0] BURST_WRAP  = 2'b10;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_EXOKAY = 2'b01;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  // Worst response wins; EXOKAY has no meaning for a split burst, so it folds to OKAY.
  function automatic logic [1:0] mergeResp(input logic [1:0] acc, input logic [1:0] resp);
    if (acc == RESP_DECERR || resp == RESP_DECERR) return RESP_DECERR;
    if (acc == RESP_SLVERR || resp == RESP_SLVERR) return RESP_SLVERR;
    return RESP_OKAY;
  endfunction

endpackage

// File: rtl/clint_split_addr_gen.sv
// Combinational next-beat address for AXI FIXED, INCR and WRAP bursts;
// the reserved burst encoding behaves as INCR.
module clint_split_addr_gen
  import clint_split_pkg::*;
#(
  parameter int AXI_ADDR_WIDTH = 64
) (
  input  logic [AXI_ADDR_WIDTH-1:0] addr_i,
  input  logic [7:0]                len_i,
  input  logic [2:0]                size_i,
  input  logic [1:0]                burst_i,
  output logic [AXI_ADDR_WIDTH-1:0] nextAddr_o
);

  logic [AXI_ADDR_WIDTH-1:0] stepSize;
  logic [AXI_ADDR_WIDTH-1:0] winSize;
  logic [AXI_ADDR_WIDTH-1:0] winMask;
  logic [AXI_ADDR_WIDTH-1:0] incrAddr;

  // The wrap window is (len+1) beats and naturally aligned, so a mask keeps the upper bits.
  always_comb begin
    stepSize = AXI_ADDR_WIDTH'(1) << size_i;
    winSize  = AXI_ADDR_WIDTH'({1'b0, len_i} + 9'd1) << size_i;
    winMask  = winSize - AXI_ADDR_WIDTH'(1);
    incrAddr = addr_i + stepSize;
    case (burst_i)
      BURST_FIXED: nextAddr_o = addr_i;
      BURST_WRAP:  nextAddr_o = (addr_i & ~winMask) | (incrAddr & winMask);
      default:     nextAddr_o = incrAddr;
    endcase
  end

endmodule

// File: rtl/clint_axi_beat_splitter.sv
// Splits upstream AXI bursts into single-beat transactions for the CLINT slave
// port; write and read paths are independent FSMs.
module clint_axi_beat_splitter
  import clint_split_pkg::*;
#(
  parameter int AXI_ADDR_WIDTH = 64,
  parameter int AXI_DATA_WIDTH = 64,
  parameter int AXI_ID_WIDTH   = 10,
  parameter int AXI_STRB_WIDTH = AXI_DATA_WIDTH / 8
) (
  input  logic                      clk,
  input  logic                      rstn,
  // upstream write address
  input  logic [AXI_ID_WIDTH-1:0]   s_aw_id,
  input  logic [AXI_ADDR_WIDTH-1:0] s_aw_addr,
  input  logic [7:0]                s_aw_len,
  input  logic [2:0]                s_aw_size,
  input  logic [1:0]                s_aw_burst,
  input  logic [5:0]                s_aw_atop,
  input  logic                      s_aw_valid,
  output logic                      s_aw_ready,
  // upstream write data
  input  logic [AXI_DATA_WIDTH-1:0] s_w_data,
  input  logic [AXI_STRB_WIDTH-1:0] s_w_strb,
  input  logic                      s_w_last,
  input  logic                      s_w_valid,
  output logic                      s_w_ready,
  // upstream write response
  output logic [AXI_ID_WIDTH-1:0]   s_b_id,
  output logic [1:0]                s_b_resp,
  output logic                      s_b_valid,
  input  logic                      s_b_ready,
  // upstream read address
  input  logic [AXI_ID_WIDTH-1:0]   s_ar_id,
  input  logic [AXI_ADDR_WIDTH-1:0] s_ar_addr,
  input  logic [7:0]                s_ar_len,
  input  logic [2:0]                s_ar_size,
  input  logic [1:0]                s_ar_burst,
  input  logic                      s_ar_valid,
  output logic                      s_ar_ready,
  // upstream read data
  output logic [AXI_ID_WIDTH-1:0]   s_r_id,
  output logic [AXI_DATA_WIDTH-1:0] s_r_data,
  output logic [1:0]                s_r_resp,
  output logic                      s_r_last,
  output logic                      s_r_valid,
  input  logic                      s_r_ready,
  // downstream write address
  output logic [AXI_ID_WIDTH-1:0]   m_aw_id,
  output logic [AXI_ADDR_WIDTH-1:0] m_aw_addr,
  output logic [7:0]                m_aw_len,
  output logic [2:0]                m_aw_size,
  output logic [1:0]                m_aw_burst,
  output logic [5:0]                m_aw_atop,
  output logic                      m_aw_valid,
  input  logic                      m_aw_ready,
  // downstream write data
  output logic [AXI_DATA_WIDTH-1:0] m_w_data,
  output logic [AXI_STRB_WIDTH-1:0] m_w_strb,
  output logic                      m_w_last,
  output logic                      m_w_valid,
  input  logic                      m_w_ready,
  // downstream write response
  input  logic [AXI_ID_WIDTH-1:0]   m_b_id,
  input  logic [1:0]                m_b_resp,
  input  logic                      m_b_valid,
  output logic                      m_b_ready,
  // downstream read address
  output logic [AXI_ID_WIDTH-1:0]   m_ar_id,
  output logic [AXI_ADDR_WIDTH-1:0] m_ar_addr,
  output logic [7:0]                m_ar_len,
  output logic [2:0]                m_ar_size,
  output logic [1:0]                m_ar_burst,
  output logic                      m_ar_valid,
  input  logic                      m_ar_ready,
  // downstream read data
  input  logic [AXI_ID_WIDTH-1:0]   m_r_id,
  input  logic [AXI_DATA_WIDTH-1:0] m_r_data,
  input  logic [1:0]                m_r_resp,
  input  logic                      m_r_last,
  input  logic                      m_r_valid,
  output logic                      m_r_ready
);

  wrState_e                  wState_q, wState_d;
  logic [AXI_ID_WIDTH-1:0]   wId_q, wId_d;
  logic [AXI_ADDR_WIDTH-1:0] wAddr_q, wAddr_d;
  logic [7:0]                wLen_q, wLen_d;
  logic [2:0]                wSize_q, wSize_d;
  logic [1:0]                wBurst_q, wBurst_d;
  logic [7:0]                wCnt_q, wCnt_d;
  logic [1:0]                wResp_q, wResp_d;
  logic                      wAtop_q, wAtop_d;

  rdState_e                  rState_q, rState_d;
  logic [AXI_ID_WIDTH-1:0]   rId_q, rId_d;
  logic [AXI_ADDR_WIDTH-1:0] rAddr_q, rAddr_d;
  logic [7:0]                rLen_q, rLen_d;
  logic [2:0]                rSize_q, rSize_d;
  logic [1:0]                rBurst_q, rBurst_d;
  logic [7:0]                rCnt_q, rCnt_d;

  // Holds the address-channel readies low until the first edge after reset release.
  logic                      readyEn_q;

  logic [AXI_ADDR_WIDTH-1:0] wNextAddr;
  logic [AXI_ADDR_WIDTH-1:0] rNextAddr;

  clint_split_addr_gen #(.AXI_ADDR_WIDTH(AXI_ADDR_WIDTH)) uWrAddrGen (
    .addr_i    (wAddr_q),
    .len_i     (wLen_q),
    .size_i    (wSize_q),
    .burst_i   (wBurst_q),
    .nextAddr_o(wNextAddr)
  );

  clint_split_addr_gen #(.AXI_ADDR_WIDTH(AXI_ADDR_WIDTH)) uRdAddrGen (
    .addr_i    (rAddr_q),
    .len_i     (rLen_q),
    .size_i    (rSize_q),
    .burst_i   (rBurst_q),
    .nextAddr_o(rNextAddr)
  );

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      readyEn_q <= 1'b0;
      wState_q  <= W_IDLE;
      wId_q     <= '0;
      wAddr_q   <= '0;
      wLen_q    <= '0;
      wSize_q   <= '0;
      wBurst_q  <= '0;
      wCnt_q    <= '0;
      wResp_q   <= '0;
      wAtop_q   <= 1'b0;
      rState_q  <= R_IDLE;
      rId_q     <= '0;
      rAddr_q   <= '0;
      rLen_q    <= '0;
      rSize_q   <= '0;
      rBurst_q  <= '0;
      rCnt_q    <= '0;
    end else begin
      readyEn_q <= 1'b1;
      wState_q  <= wState_d;
      wId_q     <= wId_d;
      wAddr_q   <= wAddr_d;
      wLen_q    <= wLen_d;
      wSize_q   <= wSize_d;
      wBurst_q  <= wBurst_d;
      wCnt_q    <= wCnt_d;
      wResp_q   <= wResp_d;
      wAtop_q   <= wAtop_d;
      rState_q  <= rState_d;
      rId_q     <= rId_d;
      rAddr_q   <= rAddr_d;
      rLen_q    <= rLen_d;
      rSize_q   <= rSize_d;
      rBurst_q  <= rBurst_d;
      rCnt_q    <= rCnt_d;
    end
  end

  // Atomics are not supported by the CLINT: their data beats are drained in W_DATA
  // without a downstream transaction and the response is preset to SLVERR.
  always_comb begin
    wState_d   = wState_q;
    wId_d      = wId_q;
    wAddr_d    = wAddr_q;
    wLen_d     = wLen_q;
    wSize_d    = wSize_q;
    wBurst_d   = wBurst_q;
    wCnt_d     = wCnt_q;
    wResp_d    = wResp_q;
    wAtop_d    = wAtop_q;
    s_aw_ready = 1'b0;
    s_w_ready  = 1'b0;
    s_b_valid  = 1'b0;
    m_aw_valid = 1'b0;
    m_w_valid  = 1'b0;
    m_b_ready  = 1'b0;
    case (wState_q)
      W_IDLE: begin
        s_aw_ready = readyEn_q;
        if (s_aw_valid && readyEn_q) begin
          wId_d    = s_aw_id;
          wAddr_d  = s_aw_addr;
          wLen_d   = s_aw_len;
          wSize_d  = s_aw_size;
          wBurst_d = s_aw_burst;
          wCnt_d   = '0;
          wAtop_d  = |s_aw_atop;
          wResp_d  = (|s_aw_atop) ? RESP_SLVERR : RESP_OKAY;
          wState_d = (|s_aw_atop) ? W_DATA : W_ADDR;
        end
      end
      W_ADDR: begin
        m_aw_valid = 1'b1;
        if (m_aw_ready) wState_d = W_DATA;
      end
      W_DATA: begin
        if (wAtop_q) begin
          s_w_ready = 1'b1;
          if (s_w_valid) begin
            if (wCnt_q == wLen_q) wState_d = W_BRESP;
            else wCnt_d = wCnt_q + 8'd1;
          end
        end else begin
          m_w_valid = s_w_valid;
          s_w_ready = m_w_ready;
          if (s_w_valid && m_w_ready) begin
            if (s_w_last && (wCnt_q != wLen_q)) wResp_d = mergeResp(wResp_q, RESP_SLVERR);
            wState_d = W_RESP;
          end
        end
      end
      W_RESP: begin
        m_b_ready = 1'b1;
        if (m_b_valid) begin
          wResp_d = mergeResp(wResp_q, m_b_resp);
          if (wCnt_q == wLen_q) begin
            wState_d = W_BRESP;
          end else begin
            wCnt_d   = wCnt_q + 8'd1;
            wAddr_d  = wNextAddr;
            wState_d = W_ADDR;
          end
        end
      end
      W_BRESP: begin
        s_b_valid = 1'b1;
        if (s_b_ready) wState_d = W_IDLE;
      end
      default: wState_d = W_IDLE;
    endcase
  end

  always_comb begin
    rState_d   = rState_q;
    rId_d      = rId_q;
    rAddr_d    = rAddr_q;
    rLen_d     = rLen_q;
    rSize_d    = rSize_q;
    rBurst_d   = rBurst_q;
    rCnt_d     = rCnt_q;
    s_ar_ready = 1'b0;
    s_r_valid  = 1'b0;
    m_ar_valid = 1'b0;
    m_r_ready  = 1'b0;
    case (rState_q)
      R_IDLE: begin
        s_ar_ready = readyEn_q;
        if (s_ar_valid && readyEn_q) begin
          rId_d    = s_ar_id;
          rAddr_d  = s_ar_addr;
          rLen_d   = s_ar_len;
          rSize_d  = s_ar_size;
          rBurst_d = s_ar_burst;
          rCnt_d   = '0;
          rState_d = R_ADDR;
        end
      end
      R_ADDR: begin
        m_ar_valid = 1'b1;
        if (m_ar_ready) rState_d = R_DATA;
      end
      R_DATA: begin
        s_r_valid = m_r_valid;
        m_r_ready = s_r_ready;
        if (m_r_valid && s_r_ready) begin
          if (rCnt_q == rLen_q) begin
            rState_d = R_IDLE;
          end else begin
            rCnt_d   = rCnt_q + 8'd1;
            rAddr_d  = rNextAddr;
            rState_d = R_ADDR;
          end
        end
      end
      default: rState_d = R_IDLE;
    endcase
  end

  assign m_aw_id    = wId_q;
  assign m_aw_addr  = wAddr_q;
  assign m_aw_len   = 8'd0;
  assign m_aw_size  = wSize_q;
  assign m_aw_burst = wBurst_q;
  assign m_aw_atop  = 6'd0;
  assign m_w_data   = s_w_data;
  assign m_w_strb   = s_w_strb;
  assign m_w_last   = 1'b1;
  assign s_b_id     = wId_q;
  assign s_b_resp   = wResp_q;

  assign m_ar_id    = rId_q;
  assign m_ar_addr  = rAddr_q;
  assign m_ar_len   = 8'd0;
  assign m_ar_size  = rSize_q;
  assign m_ar_burst = rBurst_q;
  assign s_r_id     = rId_q;
  assign s_r_data   = m_r_data;
  assign s_r_resp   = m_r_resp;
  assign s_r_last   = (rCnt_q == rLen_q);

endmodule

// File: tb/tb_clint_axi_beat_splitter.sv
// Scoreboard bench for clint_axi_beat_splitter: upstream bursts push expected
// downstream beats and upstream responses, monitors pop and compare them.
module tb_clint_axi_beat_splitter;
  import clint_split_pkg::*;

  logic clk = 1'b0;
  logic rstn = 1'b0;

  logic [9:0]  s_aw_id;   logic [63:0] s_aw_addr; logic [7:0] s_aw_len; logic [2:0] s_aw_size;
  logic [1:0]  s_aw_burst; logic [5:0] s_aw_atop; logic s_aw_valid; logic s_aw_ready;
  logic [63:0] s_w_data;  logic [7:0] s_w_strb;  logic s_w_last; logic s_w_valid; logic s_w_ready;
  logic [9:0]  s_b_id;    logic [1:0] s_b_resp;  logic s_b_valid; logic s_b_ready;
  logic [9:0]  s_ar_id;   logic [63:0] s_ar_addr; logic [7:0] s_ar_len; logic [2:0] s_ar_size;
  logic [1:0]  s_ar_burst; logic s_ar_valid; logic s_ar_ready;
  logic [9:0]  s_r_id;    logic [63:0] s_r_data; logic [1:0] s_r_resp; logic s_r_last;
  logic        s_r_valid; logic s_r_ready;
  logic [9:0]  m_aw_id;   logic [63:0] m_aw_addr; logic [7:0] m_aw_len; logic [2:0] m_aw_size;
  logic [1:0]  m_aw_burst; logic [5:0] m_aw_atop; logic m_aw_valid; logic m_aw_ready;
  logic [63:0] m_w_data;  logic [7:0] m_w_strb;  logic m_w_last; logic m_w_valid; logic m_w_ready;
  logic [9:0]  m_b_id;    logic [1:0] m_b_resp;  logic m_b_valid; logic m_b_ready;
  logic [9:0]  m_ar_id;   logic [63:0] m_ar_addr; logic [7:0] m_ar_len; logic [2:0] m_ar_size;
  logic [1:0]  m_ar_burst; logic m_ar_valid; logic m_ar_ready;
  logic [9:0]  m_r_id;    logic [63:0] m_r_data; logic [1:0] m_r_resp; logic m_r_last;
  logic        m_r_valid; logic m_r_ready;

  always #5 clk = ~clk;

  clint_axi_beat_splitter dut (
    .clk(clk), .rstn(rstn),
    .s_aw_id(s_aw_id), .s_aw_addr(s_aw_addr), .s_aw_len(s_aw_len), .s_aw_size(s_aw_size),
    .s_aw_burst(s_aw_burst), .s_aw_atop(s_aw_atop), .s_aw_valid(s_aw_valid), .s_aw_ready(s_aw_ready),
    .s_w_data(s_w_data), .s_w_strb(s_w_strb), .s_w_last(s_w_last), .s_w_valid(s_w_valid),
    .s_w_ready(s_w_ready),
    .s_b_id(s_b_id), .s_b_resp(s_b_resp), .s_b_valid(s_b_valid), .s_b_ready(s_b_ready),
    .s_ar_id(s_ar_id), .s_ar_addr(s_ar_addr), .s_ar_len(s_ar_len), .s_ar_size(s_ar_size),
    .s_ar_burst(s_ar_burst), .s_ar_valid(s_ar_valid), .s_ar_ready(s_ar_ready),
    .s_r_id(s_r_id), .s_r_data(s_r_data), .s_r_resp(s_r_resp), .s_r_last(s_r_last),
    .s_r_valid(s_r_valid), .s_r_ready(s_r_ready),
    .m_aw_id(m_aw_id), .m_aw_addr(m_aw_addr), .m_aw_len(m_aw_len), .m_aw_size(m_aw_size),
    .m_aw_burst(m_aw_burst), .m_aw_atop(m_aw_atop), .m_aw_valid(m_aw_valid), .m_aw_ready(m_aw_ready),
    .m_w_data(m_w_data), .m_w_strb(m_w_strb), .m_w_last(m_w_last), .m_w_valid(m_w_valid),
    .m_w_ready(m_w_ready),
    .m_b_id(m_b_id), .m_b_resp(m_b_resp), .m_b_valid(m_b_valid), .m_b_ready(m_b_ready),
    .m_ar_id(m_ar_id), .m_ar_addr(m_ar_addr), .m_ar_len(m_ar_len), .m_ar_size(m_ar_size),
    .m_ar_burst(m_ar_burst), .m_ar_valid(m_ar_valid), .m_ar_ready(m_ar_ready),
    .m_r_id(m_r_id), .m_r_data(m_r_data), .m_r_resp(m_r_resp), .m_r_last(m_r_last),
    .m_r_valid(m_r_valid), .m_r_ready(m_r_ready)
  );

  typedef struct { logic [63:0] addr; logic [9:0] id; logic [2:0] size; } axExp_t;
  typedef struct { logic [9:0] id; logic [63:0] data; logic last; } rExp_t;

  localparam logic [63:0] RKEY = 64'hDEAD_BEEF_0000_0000;

  axExp_t      expAwQ[$];
  axExp_t      expArQ[$];
  logic [63:0] expWQ[$];
  logic [1:0]  bRespQ[$];
  logic [11:0] expBQ[$];
  logic [63:0] rSlaveQ[$];
  rExp_t       expRQ[$];

  int total = 0;
  int bad = 0;
  int bPend = 0;
  int bDone = 0;
  int rDone = 0;
  bit stall = 1'b0;
  bit abortFlag = 1'b0;
  bit bFire = 1'b0;
  bit rFire = 1'b0;

  task automatic checkOutput(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("[TB] FAIL %s got=%0h exp=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] modelNext(input logic [63:0] a, input int len,
                                            input logic [2:0] size, input logic [1:0] burst);
    logic [63:0] step, win, base, off;
    step = 64'd1 << size;
    win  = 64'(len + 1) * step;
    case (burst)
      2'b00: return a;
      2'b10: begin
        base = a - (a % win);
        off  = a - base + step;
        if (off >= win) off = off - win;
        return base + off;
      end
      default: return a + step;
    endcase
  endfunction

  function automatic logic [63:0] wData(input logic [9:0] id, input int i);
    return {32'hC0DE_0000 | 32'(i), 22'h0, id};
  endfunction

  // Handshakes are evaluated at negedge: valid&&ready there means transfer at the next posedge.
  always @(negedge clk) begin
    axExp_t ea;
    rExp_t er;
    logic [63:0] d;
    bFire = 1'b0;
    rFire = 1'b0;
    if (rstn) begin
      if (m_aw_valid && m_aw_ready) begin
        if (expAwQ.size() == 0) checkOutput("m_aw_unexpected", m_aw_valid, 1'b0);
        else begin
          ea = expAwQ.pop_front();
          checkOutput("m_aw_addr", m_aw_addr, ea.addr);
          checkOutput("m_aw_id", m_aw_id, ea.id);
          checkOutput("m_aw_size", m_aw_size, ea.size);
          checkOutput("m_aw_len_atop", {m_aw_len, m_aw_atop}, 0);
        end
      end
      if (m_w_valid && m_w_ready) begin
        if (expWQ.size() == 0) checkOutput("m_w_unexpected", m_w_valid, 1'b0);
        else begin
          d = expWQ.pop_front();
          checkOutput("m_w_data", m_w_data, d);
          checkOutput("m_w_last", m_w_last, 1'b1);
        end
        bPend++;
      end
      if (m_b_valid && m_b_ready) begin
        bFire = 1'b1;
        bPend--;
        if (bRespQ.size() > 0) void'(bRespQ.pop_front());
      end
      if (s_b_valid && s_b_ready) begin
        if (expBQ.size() == 0) checkOutput("s_b_unexpected", s_b_valid, 1'b0);
        else checkOutput("s_b_id_resp", {s_b_id, s_b_resp}, expBQ.pop_front());
        bDone++;
      end
      if (m_r_valid && m_r_ready) begin
        rFire = 1'b1;
        if (rSlaveQ.size() > 0) void'(rSlaveQ.pop_front());
      end
      if (m_ar_valid && m_ar_ready) begin
        if (expArQ.size() == 0) checkOutput("m_ar_unexpected", m_ar_valid, 1'b0);
        else begin
          ea = expArQ.pop_front();
          checkOutput("m_ar_addr", m_ar_addr, ea.addr);
          checkOutput("m_ar_id", m_ar_id, ea.id);
          checkOutput("m_ar_len", m_ar_len, 0);
        end
        rSlaveQ.push_back(m_ar_addr);
      end
      if (s_r_valid && s_r_ready) begin
        if (expRQ.size() == 0) checkOutput("s_r_unexpected", s_r_valid, 1'b0);
        else begin
          er = expRQ.pop_front();
          checkOutput("s_r_data", s_r_data, er.data);
          checkOutput("s_r_id_last", {s_r_id, s_r_last}, {er.id, er.last});
          checkOutput("s_r_resp", s_r_resp, RESP_OKAY);
        end
        rDone++;
      end
    end
  end

  // Downstream slave model and upstream ready stalls.
  always @(posedge clk) begin
    #1;
    m_aw_ready = stall ? 1'($urandom_range(0, 1)) : 1'b1;
    m_w_ready  = stall ? 1'($urandom_range(0, 1)) : 1'b1;
    m_ar_ready = stall ? 1'($urandom_range(0, 1)) : 1'b1;
    s_b_ready  = stall ? 1'($urandom_range(0, 1)) : 1'b1;
    s_r_ready  = stall ? 1'($urandom_range(0, 1)) : 1'b1;
    if (!rstn) begin
      m_b_valid = 1'b0;
      m_r_valid = 1'b0;
    end else begin
      if (bFire) m_b_valid = 1'b0;
      if (!m_b_valid && bPend > 0) begin
        m_b_valid = 1'b1;
        m_b_resp  = (bRespQ.size() > 0) ? bRespQ[0] : RESP_OKAY;
      end
      if (rFire) m_r_valid = 1'b0;
      if (!m_r_valid && rSlaveQ.size() > 0) begin
        m_r_valid = 1'b1;
        m_r_data  = rSlaveQ[0] ^ RKEY;
        m_r_resp  = RESP_OKAY;
        m_r_last  = 1'b1;
      end
    end
  end

  task automatic waitHandshake(input int which, input string tag, output bit ok);
    bit seen;
    ok = 1'b0;
    for (int n = 0; n < 3000; n++) begin
      @(negedge clk);
      if (abortFlag) return;
      case (which)
        0:       seen = s_aw_ready;
        1:       seen = s_w_ready;
        default: seen = s_ar_ready;
      endcase
      if (seen) begin
        ok = 1'b1;
        return;
      end
    end
    checkOutput(tag, ok, 1'b1);
  endtask

  task automatic waitDone(input bit isRead, input int target, input string tag);
    int cnt;
    for (int n = 0; n < 20000; n++) begin
      @(negedge clk);
      if (abortFlag) return;
      cnt = isRead ? rDone : bDone;
      if (cnt >= target) return;
    end
    checkOutput(tag, cnt, target);
  endtask

  task automatic applyStimulusWrite(input logic [9:0] id, input logic [63:0] addr, input int len,
                                    input logic [2:0] size, input logic [1:0] burst,
                                    input logic [5:0] atop, input bit earlyLast);
    logic [63:0] a;
    int startB;
    bit ok;
    a = addr;
    for (int i = 0; i <= len; i++) begin
      if (atop == 6'd0) begin
        expAwQ.push_back('{addr: a, id: id, size: size});
        expWQ.push_back(wData(id, i));
      end
      a = modelNext(a, len, size, burst);
    end
    startB = bDone;
    @(posedge clk); #1;
    s_aw_id = id; s_aw_addr = addr; s_aw_len = 8'(len); s_aw_size = size;
    s_aw_burst = burst; s_aw_atop = atop; s_aw_valid = 1'b1;
    waitHandshake(0, "aw_timeout", ok);
    @(posedge clk); #1;
    s_aw_valid = 1'b0;
    if (!ok) return;
    for (int i = 0; i <= len; i++) begin
      s_w_data = wData(id, i); s_w_strb = 8'hFF;
      s_w_last = earlyLast ? 1'b1 : (i == len);
      s_w_valid = 1'b1;
      waitHandshake(1, "w_timeout", ok);
      @(posedge clk); #1;
      s_w_valid = 1'b0;
      if (!ok) return;
    end
    waitDone(1'b0, startB + 1, "b_timeout");
  endtask

  task automatic applyStimulusRead(input logic [9:0] id, input logic [63:0] addr, input int len,
                                   input logic [2:0] size, input logic [1:0] burst);
    logic [63:0] a;
    int startR;
    bit ok;
    a = addr;
    for (int i = 0; i <= len; i++) begin
      expArQ.push_back('{addr: a, id: id, size: size});
      expRQ.push_back('{id: id, data: a ^ RKEY, last: (i == len)});
      a = modelNext(a, len, size, burst);
    end
    startR = rDone;
    @(posedge clk); #1;
    s_ar_id = id; s_ar_addr = addr; s_ar_len = 8'(len); s_ar_size = size;
    s_ar_burst = burst; s_ar_valid = 1'b1;
    waitHandshake(2, "ar_timeout", ok);
    @(posedge clk); #1;
    s_ar_valid = 1'b0;
    if (!ok) return;
    waitDone(1'b1, startR + len + 1, "r_timeout");
  endtask

  initial begin
    #900000;
    $display("[TB] FAIL watchdog got=hang exp=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    s_aw_valid = 0; s_aw_id = 0; s_aw_addr = 0; s_aw_len = 0; s_aw_size = 0; s_aw_burst = 0;
    s_aw_atop = 0; s_w_valid = 0; s_w_data = 0; s_w_strb = 0; s_w_last = 0;
    s_ar_valid = 0; s_ar_id = 0; s_ar_addr = 0; s_ar_len = 0; s_ar_size = 0; s_ar_burst = 0;
    s_b_ready = 1; s_r_ready = 1; m_aw_ready = 1; m_w_ready = 1; m_ar_ready = 1;
    m_b_valid = 0; m_b_id = 0; m_b_resp = 0; m_r_valid = 0; m_r_id = 0; m_r_data = 0;
    m_r_resp = 0; m_r_last = 0;

    repeat (3) @(posedge clk);
    @(negedge clk);
    checkOutput("rst_readies", {s_aw_ready, s_ar_ready}, 2'b00);
    checkOutput("rst_valids", {m_aw_valid, m_w_valid, m_ar_valid, s_b_valid, s_r_valid}, 0);
    rstn = 1'b1;
    @(negedge clk);
    checkOutput("post_rst_readies", {s_aw_ready, s_ar_ready}, 2'b11);

    // Single-error and merge cases.
    bRespQ.push_back(RESP_OKAY); bRespQ.push_back(RESP_OKAY);
    expBQ.push_back({10'h015, RESP_OKAY});
    applyStimulusWrite(10'h015, 64'h0200_4000, 1, 3'd3, BURST_INCR, 6'd0, 1'b0);
    applyStimulusRead(10'h02A, 64'h0200_BFF8, 1, 3'd3, BURST_WRAP);
    bRespQ.push_back(RESP_SLVERR);
    expBQ.push_back({10'h003, RESP_SLVERR});
    applyStimulusWrite(10'h003, 64'h0200_0000, 0, 3'd3, BURST_INCR, 6'd0, 1'b0);
    bRespQ.push_back(RESP_OKAY); bRespQ.push_back(RESP_DECERR);
    bRespQ.push_back(RESP_SLVERR); bRespQ.push_back(RESP_OKAY);
    expBQ.push_back({10'h044, RESP_DECERR});
    applyStimulusWrite(10'h044, 64'h0200_0100, 3, 3'd3, BURST_INCR, 6'd0, 1'b0);
    expBQ.push_back({10'h055, RESP_SLVERR});
    applyStimulusWrite(10'h055, 64'h0200_0200, 1, 3'd3, BURST_INCR, 6'h20, 1'b0);
    bRespQ.push_back(RESP_EXOKAY); bRespQ.push_back(RESP_EXOKAY);
    expBQ.push_back({10'h066, RESP_OKAY});
    applyStimulusWrite(10'h066, 64'h0200_0300, 1, 3'd3, BURST_INCR, 6'd0, 1'b0);
    bRespQ.push_back(RESP_OKAY); bRespQ.push_back(RESP_OKAY);
    expBQ.push_back({10'h077, RESP_SLVERR});
    applyStimulusWrite(10'h077, 64'h0200_0400, 1, 3'd3, BURST_INCR, 6'd0, 1'b1);

    // Address generation corners.
    applyStimulusRead(10'h101, 64'h0000_1000, 2, 3'd2, BURST_FIXED);
    applyStimulusRead(10'h102, 64'h0000_2000, 1, 3'd2, 2'b11);
    for (int i = 0; i < 4; i++) bRespQ.push_back(RESP_OKAY);
    expBQ.push_back({10'h103, RESP_OKAY});
    applyStimulusWrite(10'h103, 64'h0200_0034, 3, 3'd2, BURST_WRAP, 6'd0, 1'b0);
    bRespQ.push_back(RESP_OKAY); bRespQ.push_back(RESP_OKAY);
    expBQ.push_back({10'h104, RESP_OKAY});
    applyStimulusWrite(10'h104, 64'hFFFF_FFFF_FFFF_FFF8, 1, 3'd3, BURST_INCR, 6'd0, 1'b0);
    applyStimulusRead(10'h105, 64'h0000_0100, 255, 3'd0, BURST_INCR);

    // Concurrent traffic with random stalls.
    stall = 1'b1;
    for (int i = 0; i < 3; i++) bRespQ.push_back(RESP_OKAY);
    expBQ.push_back({10'h201, RESP_OKAY});
    fork
      applyStimulusWrite(10'h201, 64'h0200_5000, 2, 3'd3, BURST_INCR, 6'd0, 1'b0);
      applyStimulusRead(10'h202, 64'h0200_6000, 2, 3'd3, BURST_INCR);
    join

    // Reset in the middle of concurrent bursts.
    for (int i = 0; i < 3; i++) bRespQ.push_back(RESP_OKAY);
    expBQ.push_back({10'h301, RESP_OKAY});
    fork
      applyStimulusWrite(10'h301, 64'h0200_7000, 2, 3'd3, BURST_INCR, 6'd0, 1'b0);
      applyStimulusRead(10'h302, 64'h0200_8000, 2, 3'd3, BURST_INCR);
      begin
        repeat (7) @(posedge clk);
        #3;
        abortFlag = 1'b1;
        rstn = 1'b0;
        @(negedge clk);
        checkOutput("midrst_valids",
                    {m_aw_valid, m_w_valid, m_ar_valid, s_b_valid, s_r_valid, s_aw_ready, s_ar_ready}, 0);
        repeat (3) @(posedge clk);
      end
    join
    #1;
    expAwQ.delete(); expArQ.delete(); expWQ.delete(); bRespQ.delete();
    expBQ.delete(); rSlaveQ.delete(); expRQ.delete();
    bPend = 0;
    s_aw_valid = 0; s_w_valid = 0; s_ar_valid = 0;
    abortFlag = 1'b0;
    @(negedge clk);
    rstn = 1'b1;
    @(negedge clk);
    checkOutput("rerst_idle", {s_aw_ready, s_ar_ready, s_b_valid, s_r_valid}, 4'b1100);

    for (int i = 0; i < 3; i++) bRespQ.push_back(RESP_OKAY);
    expBQ.push_back({10'h311, RESP_OKAY});
    fork
      applyStimulusWrite(10'h311, 64'h0200_9000, 2, 3'd3, BURST_INCR, 6'd0, 1'b0);
      applyStimulusRead(10'h312, 64'h0200_A008, 2, 3'd3, BURST_INCR);
    join

    repeat (5) @(posedge clk);
    checkOutput("queues_drained",
                expAwQ.size() + expArQ.size() + expWQ.size() + expBQ.size() + expRQ.size() + bRespQ.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
